// File: rtl/matmul_tile_scheduler_if.sv
// matmul_tile_scheduler_if: BRAM port-B reads (in_enb/in_addrb, wb_enb/wb_addrb) and systolic core control (core_en, core_rst_n, core_reset_acc, systolic_finish, accumulator_done)
interface matmul_tile_scheduler_if #(
  parameter int ADDR_WIDTH_I = 14,
  parameter int ADDR_WIDTH_W = 12
);
  logic in_enb;
  logic [ADDR_WIDTH_I-1:0] in_addrb;
  logic wb_enb;
  logic [ADDR_WIDTH_W-1:0] wb_addrb;
  logic core_en;
  logic core_rst_n;
  logic core_reset_acc;
  logic systolic_finish;
  logic accumulator_done;
  modport master (
    output in_enb, in_addrb, wb_enb, wb_addrb, core_en, core_rst_n, core_reset_acc,
    input  systolic_finish, accumulator_done
  );
  modport slave (
    input  in_enb, in_addrb, wb_enb, wb_addrb, core_en, core_rst_n, core_reset_acc,
    output systolic_finish, accumulator_done
  );
endinterface

// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler: row-major tile / K-step FSM for C = I x W; ports clk, rst, start, abort, busy, done, tile_row, tile_col, bus (BRAM reads + core control)
module matmul_tile_scheduler #(
  parameter int INNER_DIMENSION   = 4,
  parameter int BLOCK_SIZE        = 2,
  parameter int I_OUTER_DIMENSION = 6,
  parameter int W_OUTER_DIMENSION = 6,
  parameter int ADDR_WIDTH_I      = 14,
  parameter int ADDR_WIDTH_W      = 12,
  localparam int K_STEPS = INNER_DIMENSION / BLOCK_SIZE,
  localparam int ROWS    = I_OUTER_DIMENSION / BLOCK_SIZE,
  localparam int COLS    = W_OUTER_DIMENSION / BLOCK_SIZE,
  localparam int KW      = K_STEPS > 1 ? $clog2(K_STEPS) : 1,
  localparam int RW      = ROWS > 1 ? $clog2(ROWS) : 1,
  localparam int CW      = COLS > 1 ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] tile_row,
  output logic [CW-1:0] tile_col,
  matmul_tile_scheduler_if.master bus
);
  localparam int MAXRC = ROWS > COLS ? ROWS : COLS;
  if (INNER_DIMENSION % BLOCK_SIZE != 0 || I_OUTER_DIMENSION % BLOCK_SIZE != 0 ||
      W_OUTER_DIMENSION % BLOCK_SIZE != 0) begin : g_dim_chk
    $error("matmul_tile_scheduler: dimensions must be multiples of BLOCK_SIZE");
  end
  if (longint'(K_STEPS) * longint'(MAXRC) > (longint'(1) << ADDR_WIDTH_I) ||
      longint'(K_STEPS) * longint'(MAXRC) > (longint'(1) << ADDR_WIDTH_W)) begin : g_addr_chk
    $error("matmul_tile_scheduler: block addresses overflow BRAM address width");
  end
  typedef enum logic [3:0] {IDLE, ACC_CLR, FETCH, WAIT, RUN, SYS_CLR, DRAIN, ADVANCE, DONE} state_t;
  state_t state, state_n;
  logic [KW-1:0] k, k_n;
  logic [RW-1:0] row_n;
  logic [CW-1:0] col_n;
  logic last_k, last_row, last_col;
  always_comb begin
    last_k   = k == KW'(K_STEPS - 1);
    last_row = tile_row == RW'(ROWS - 1);
    last_col = tile_col == CW'(COLS - 1);
    state_n  = state;
    k_n      = k;
    row_n    = tile_row;
    col_n    = tile_col;
    case (state)
      IDLE:    if (start) begin
                 state_n = ACC_CLR;
                 k_n     = '0;
                 row_n   = '0;
                 col_n   = '0;
               end
      ACC_CLR: state_n = FETCH;
      FETCH:   state_n = WAIT;
      WAIT:    state_n = RUN;
      RUN:     if (bus.systolic_finish)
                 state_n = !last_k ? SYS_CLR : bus.accumulator_done ? ADVANCE : DRAIN;
      SYS_CLR: begin
                 state_n = FETCH;
                 k_n     = k + KW'(1);
               end
      DRAIN:   if (bus.accumulator_done) state_n = ADVANCE;
      ADVANCE: begin
                 state_n = last_col && last_row ? DONE : ACC_CLR;
                 k_n     = '0;
                 col_n   = last_col ? '0 : tile_col + CW'(1);
                 row_n   = !last_col ? tile_row : last_row ? '0 : tile_row + RW'(1);
               end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE && state != DONE) begin
      state_n = IDLE;
      k_n     = '0;
      row_n   = '0;
      col_n   = '0;
    end
  end
  // Outputs are registered from the next state so every output is a flop.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state              <= IDLE;
      k                  <= '0;
      tile_row           <= '0;
      tile_col           <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      bus.in_enb         <= 1'b0;
      bus.wb_enb         <= 1'b0;
      bus.in_addrb       <= '0;
      bus.wb_addrb       <= '0;
      bus.core_en        <= 1'b0;
      bus.core_rst_n     <= 1'b0;
      bus.core_reset_acc <= 1'b1;
    end else begin
      state              <= state_n;
      k                  <= k_n;
      tile_row           <= row_n;
      tile_col           <= col_n;
      busy               <= state_n != IDLE;
      done               <= state_n == DONE;
      bus.in_enb         <= state_n inside {FETCH, WAIT, RUN};
      bus.wb_enb         <= state_n inside {FETCH, WAIT, RUN};
      bus.in_addrb       <= ADDR_WIDTH_I'(32'(k_n) + 32'(K_STEPS) * 32'(row_n));
      bus.wb_addrb       <= ADDR_WIDTH_W'(32'(k_n) + 32'(K_STEPS) * 32'(col_n));
      bus.core_en        <= state_n inside {RUN, DRAIN};
      bus.core_rst_n     <= state_n == RUN;
      bus.core_reset_acc <= state_n inside {IDLE, ACC_CLR};
    end
endmodule
